accel_mem_sequencer: RTL and testbench
======================================

ACCEL_MEM_SEQUENCER -- requirements
Module: accel_mem_sequencer

Interface
REQ-001 Parameter ADDR_W, default 8: slave address width per channel.
REQ-002 Parameter DATA_W, default 64: slave data width per channel.
REQ-003 Parameter SIZE_W, default 7: slave access-size field width per channel.
REQ-004 Parameter NWORDS, default 16: number of 32-bit words preloaded and read back.
REQ-005 Parameter BASE_ADDR, default 0: byte address of word 0; word i is at BASE_ADDR+4*i.
REQ-006 Parameter MAX_CYCLES, default 200000000: watchdog limit in clocks.
REQ-007 clock  in  1  single clock; all logic on rising edge.
REQ-008 reset  in  1  synchronous, active-high.
REQ-009 go  in  1  starts a sequence when sampled high in IDLE.
REQ-010 ld_valid / ld_data / ld_ready  in / in 32 / out  preload word stream.
REQ-011 acc_start_port  out  1  start pulse to accelerator.
REQ-012 acc_done_port  in  1  accelerator completion.
REQ-013 S_oe_ram  out 2;  S_we_ram  out 2;  S_addr_ram  out 2*ADDR_W;  S_Wdata_ram  out 2*DATA_W;  S_data_ram_size  out 2*SIZE_W  slave memory request; channel 0 only, channel 1 fields driven 0.
REQ-014 Sout_Rdata_ram  in 2*DATA_W;  Sout_DataRdy  in 2  slave response; channel 0 used.
REQ-015 rd_valid / rd_data / rd_ready  out / out 32 / in  readback word stream.
REQ-016 busy out 1; done out 1 (one-cycle pulse); timeout out 1 (sticky until next go); cycles out 32.

Function
REQ-017 States: IDLE, LOAD, START, RUN, RD_REQ, RD_OUT, FINISH.
REQ-018 IDLE: go=1 -> LOAD, word index cleared, timeout and cycles cleared; busy=0 only in IDLE.
REQ-019 LOAD: ld_ready=1 when no write outstanding; on ld_valid&ld_ready assert S_we_ram[0], address BASE_ADDR+4*index, Wdata low 32 bits = ld_data (upper bits 0), size = 32.
REQ-020 Write request held stable until Sout_DataRdy[0]=1 is sampled; then deasserted the next cycle and index incremented; ld_ready=0 while held.
REQ-021 After write NWORDS-1 is acknowledged -> START.
REQ-022 START: acc_start_port=1 for exactly one cycle, cycle counter set to 1 -> RUN.
REQ-023 RUN: counter increments each cycle; acc_done_port=1 sampled -> cycles latches counter (START cycle to done cycle inclusive, so done in cycle after start gives 2), index cleared -> RD_REQ.
REQ-024 acc_done_port sampled in any state other than RUN is ignored.
REQ-025 RD_REQ: assert S_oe_ram[0], address BASE_ADDR+4*index, size 32, held until Sout_DataRdy[0]=1; capture Rdata[31:0] -> RD_OUT.
REQ-026 RD_OUT: rd_valid=1, rd_data stable until rd_ready=1; on handshake, last word -> FINISH else index+1 -> RD_REQ.
REQ-027 FINISH: done=1 one cycle -> IDLE.
REQ-028 S_oe_ram[0] and S_we_ram[0] never high simultaneously; go ignored while busy=1.
REQ-029 Index width is clog2(NWORDS)+1; no wrap; address arithmetic truncated to ADDR_W.

Reset
REQ-030 reset=1 at a rising edge forces IDLE regardless of state, including mid-write or mid-read, and aborts any outstanding slave request.
REQ-031 Reset values: all outputs 0 except busy=0, ld_ready=0; cycles=0; timeout=0.

Configuration
REQ-032 Macro ACCEL_SEQ_WATCHDOG_EN defined: in RUN, when counter exceeds MAX_CYCLES, timeout=1, cycles=MAX_CYCLES, readback skipped -> FINISH.
REQ-033 Macro undefined: no watchdog; RUN waits indefinitely; timeout tied 0; counter saturates at 32'hFFFF_FFFF.

Verification
REQ-034 NWORDS=4, load 4,3,2,1 with DataRdy same cycle -> 4 we pulses at addresses 0,4,8,12, one start pulse.
REQ-035 Model sorts and raises done 10 cycles after start; read data 1,2,3,4 -> rd_data stream 1,2,3,4, cycles=11, done pulse once.
REQ-036 DataRdy delayed 2 cycles per access, rd_ready low 3 cycles per word -> request and rd_data held stable, no lost or duplicated words.
REQ-037 reset asserted during second LOAD write -> next cycle IDLE, all outputs 0; a new go restarts at word 0 address BASE_ADDR.
REQ-038 With ACCEL_SEQ_WATCHDOG_EN, MAX_CYCLES=20, done never raised -> timeout=1, cycles=20, no oe access, done pulse.
REQ-039 go pulsed during RUN and done pulsed during LOAD -> both ignored; sequence order unchanged.

Source files
------------

// File: rtl/accel_mem_sequencer.sv
// Preloads a word block into slave memory, kicks the accelerator, reads it back.
// Define ACCEL_SEQ_WATCHDOG_EN to bound the RUN wait by MAX_CYCLES.
module accel_mem_sequencer #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 64,
  parameter int SIZE_W     = 7,
  parameter int NWORDS     = 16,
  parameter int BASE_ADDR  = 0,
  parameter int MAX_CYCLES = 200000000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  go,
  input  logic                  ld_valid,
  input  logic [31:0]           ld_data,
  output logic                  ld_ready,
  output logic                  acc_start_port,
  input  logic                  acc_done_port,
  output logic [1:0]            S_oe_ram,
  output logic [1:0]            S_we_ram,
  output logic [2*ADDR_W-1:0]   S_addr_ram,
  output logic [2*DATA_W-1:0]   S_Wdata_ram,
  output logic [2*SIZE_W-1:0]   S_data_ram_size,
  input  logic [2*DATA_W-1:0]   Sout_Rdata_ram,
  input  logic [1:0]            Sout_DataRdy,
  output logic                  rd_valid,
  output logic [31:0]           rd_data,
  input  logic                  rd_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout,
  output logic [31:0]           cycles
);

  localparam int IDX_W = $clog2(NWORDS) + 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NWORDS - 1);
  localparam logic [SIZE_W-1:0] SIZE32 = SIZE_W'(32);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_RUN,
    S_RD_REQ,
    S_RD_OUT,
    S_FINISH
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             wr_pend_q, wr_pend_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [31:0]      cnt_q, cnt_d;
  logic [31:0]      cycles_q, cycles_d;
  logic             timeout_q, timeout_d;
  logic [31:0]      cnt_inc;
  logic [ADDR_W-1:0] addr;
  logic             unused_in;

  assign unused_in = ^{Sout_Rdata_ram[2*DATA_W-1:32], Sout_DataRdy[1]};

  // Counter holds at all-ones rather than wrapping.
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 32'd1;
  assign addr = ADDR_W'(BASE_ADDR) + (ADDR_W'(idx_q) << 2);

  always_comb begin
    state_d         = state_q;
    idx_d           = idx_q;
    wr_pend_d       = wr_pend_q;
    wdata_d         = wdata_q;
    rdata_d         = rdata_q;
    cnt_d           = cnt_q;
    cycles_d        = cycles_q;
    timeout_d       = timeout_q;
    ld_ready        = 1'b0;
    acc_start_port  = 1'b0;
    rd_valid        = 1'b0;
    rd_data         = '0;
    S_oe_ram        = '0;
    S_we_ram        = '0;
    S_addr_ram      = '0;
    S_Wdata_ram     = '0;
    S_data_ram_size = '0;

    unique case (state_q)
      S_IDLE: begin
        if (go) begin
          state_d   = S_LOAD;
          idx_d     = '0;
          cnt_d     = '0;
          cycles_d  = '0;
          timeout_d = 1'b0;
        end
      end
      S_LOAD: begin
        ld_ready = !wr_pend_q;
        if (wr_pend_q) begin
          S_we_ram[0]                     = 1'b1;
          S_addr_ram[ADDR_W-1:0]          = addr;
          S_Wdata_ram[31:0]               = wdata_q;
          S_data_ram_size[SIZE_W-1:0]     = SIZE32;
          if (Sout_DataRdy[0]) begin
            wr_pend_d = 1'b0;
            idx_d     = idx_q + 1'b1;
            if (idx_q == LAST) state_d = S_START;
          end
        end else if (ld_valid) begin
          wr_pend_d = 1'b1;
          wdata_d   = ld_data;
        end
      end
      S_START: begin
        acc_start_port = 1'b1;
        cnt_d          = 32'd1;
        state_d        = S_RUN;
      end
      S_RUN: begin
        cnt_d = cnt_inc;
        if (acc_done_port) begin
          cycles_d = cnt_inc;
          idx_d    = '0;
          state_d  = S_RD_REQ;
        end
`ifdef ACCEL_SEQ_WATCHDOG_EN
        else if ({1'b0, cnt_q} >= 33'(MAX_CYCLES)) begin
          timeout_d = 1'b1;
          cycles_d  = 32'(MAX_CYCLES);
          state_d   = S_FINISH;
        end
`endif
      end
      S_RD_REQ: begin
        S_oe_ram[0]                 = 1'b1;
        S_addr_ram[ADDR_W-1:0]      = addr;
        S_data_ram_size[SIZE_W-1:0] = SIZE32;
        if (Sout_DataRdy[0]) begin
          rdata_d = Sout_Rdata_ram[31:0];
          state_d = S_RD_OUT;
        end
      end
      S_RD_OUT: begin
        rd_valid = 1'b1;
        rd_data  = rdata_q;
        if (rd_ready) begin
          if (idx_q == LAST) begin
            state_d = S_FINISH;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_RD_REQ;
          end
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      wr_pend_q <= 1'b0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      cnt_q     <= '0;
      cycles_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      wr_pend_q <= wr_pend_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      cnt_q     <= cnt_d;
      cycles_q  <= cycles_d;
      timeout_q <= timeout_d;
    end
  end

  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_FINISH);
  assign timeout = timeout_q;
  assign cycles  = cycles_q;

endmodule

// File: tb/tb_accel_mem_sequencer.sv
// Bench for accel_mem_sequencer: slave memory + sorting accelerator models,
// table vectors, reset/spurious-input sequences and randomized runs.
module tb_accel_mem_sequencer;

  localparam int NW = 4;
`ifdef ACCEL_SEQ_WATCHDOG_EN
  localparam int MAXC = 20;
`else
  localparam int MAXC = 200000000;
`endif

  logic clk = 1'b0;
  logic reset, go, ld_valid, ld_ready;
  logic [31:0] ld_data;
  logic acc_start_port, acc_done_port;
  logic [1:0] S_oe_ram, S_we_ram, Sout_DataRdy;
  logic [15:0] S_addr_ram;
  logic [127:0] S_Wdata_ram, Sout_Rdata_ram;
  logic [13:0] S_data_ram_size;
  logic rd_valid, rd_ready, busy, done, timeout;
  logic [31:0] rd_data, cycles;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  accel_mem_sequencer #(
    .ADDR_W(8), .DATA_W(64), .SIZE_W(7), .NWORDS(NW),
    .BASE_ADDR(0), .MAX_CYCLES(MAXC)
  ) dut (
    .clock(clk), .reset(reset), .go(go),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
    .acc_start_port(acc_start_port), .acc_done_port(acc_done_port),
    .S_oe_ram(S_oe_ram), .S_we_ram(S_we_ram), .S_addr_ram(S_addr_ram),
    .S_Wdata_ram(S_Wdata_ram), .S_data_ram_size(S_data_ram_size),
    .Sout_Rdata_ram(Sout_Rdata_ram), .Sout_DataRdy(Sout_DataRdy),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_ready(rd_ready),
    .busy(busy), .done(done), .timeout(timeout), .cycles(cycles)
  );

  // slave memory and accelerator models
  logic [31:0] mem [64];
  int slv_delay = 0;
  int slv_wc = 0;
  logic slv_req;
  int acc_lat = 5;
  bit acc_hang = 1'b0;
  logic acc_done_force;
  logic acc_act = 1'b0;
  int acc_left = 0;
  logic [31:0] sq [$];

  always_comb begin
    slv_req = S_we_ram[0] | S_oe_ram[0];
    Sout_DataRdy = {1'b0, slv_req && (slv_wc >= slv_delay)};
    Sout_Rdata_ram = {64'hA5A5_5A5A_C3C3_3C3C, 32'hDEAD_BEEF, mem[S_addr_ram[7:2]]};
  end

  assign acc_done_port = (acc_act && acc_left == 0) || acc_done_force;

  always @(posedge clk) begin
    if (slv_req && !Sout_DataRdy[0]) slv_wc <= slv_wc + 1;
    else slv_wc <= 0;
    if (S_we_ram[0] && Sout_DataRdy[0])
      mem[S_addr_ram[7:2]] <= S_Wdata_ram[31:0];
    if (reset) begin
      acc_act <= 1'b0;
    end else if (acc_start_port) begin
      sq = {};
      for (int i = 0; i < NW; i++) sq.push_back(mem[i]);
      sq.sort();
      for (int i = 0; i < NW; i++) mem[i] <= sq[i];
      acc_act <= !acc_hang;
      acc_left <= acc_lat - 1;
    end else if (acc_act) begin
      if (acc_left == 0) acc_act <= 1'b0;
      else acc_left <= acc_left - 1;
    end
  end

  // bus monitor
  logic [7:0] wr_addr [$];
  logic [31:0] wr_data [$];
  logic [31:0] rd_log [$];
  int we_rise = 0, oe_rise = 0, start_cnt = 0, done_cnt = 0;
  int proto_err = 0, stab_err = 0;
  logic we_prev = 1'b0, oe_prev = 1'b0;
  logic hold_w = 1'b0, hold_r = 1'b0, hold_d = 1'b0;
  logic [7:0] hw_addr, hr_addr;
  logic [31:0] hw_data, hd_data;

  always @(posedge clk) begin
    if (S_we_ram[0] && S_oe_ram[0]) proto_err++;
    if (S_we_ram[1] || S_oe_ram[1] || S_addr_ram[15:8] != 0 ||
        S_Wdata_ram[127:64] != 0 || S_data_ram_size[13:7] != 0) proto_err++;
    if ((S_we_ram[0] || S_oe_ram[0]) && S_data_ram_size[6:0] != 7'd32) proto_err++;
    if (S_we_ram[0] && S_Wdata_ram[63:32] != 0) proto_err++;
    if (S_we_ram[0] && Sout_DataRdy[0]) begin
      wr_addr.push_back(S_addr_ram[7:0]);
      wr_data.push_back(S_Wdata_ram[31:0]);
    end
    if (S_we_ram[0] && !we_prev) we_rise++;
    if (S_oe_ram[0] && !oe_prev) oe_rise++;
    we_prev = S_we_ram[0];
    oe_prev = S_oe_ram[0];
    if (acc_start_port) start_cnt++;
    if (done) done_cnt++;
    if (rd_valid && rd_ready) rd_log.push_back(rd_data);
    if (hold_w && !(S_we_ram[0] && S_addr_ram[7:0] == hw_addr &&
                    S_Wdata_ram[31:0] == hw_data)) stab_err++;
    if (hold_r && !(S_oe_ram[0] && S_addr_ram[7:0] == hr_addr)) stab_err++;
    if (hold_d && !(rd_valid && rd_data == hd_data)) stab_err++;
    hold_w = S_we_ram[0] && !Sout_DataRdy[0] && !reset;
    hold_r = S_oe_ram[0] && !Sout_DataRdy[0] && !reset;
    hold_d = rd_valid && !rd_ready && !reset;
    hw_addr = S_addr_ram[7:0];
    hr_addr = S_addr_ram[7:0];
    hw_data = S_Wdata_ram[31:0];
    hd_data = rd_data;
  end

  // readback consumer: holds rd_ready low rd_gap cycles per word
  int rd_gap = 0;
  int rd_wait = 0;
  initial begin
    rd_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (rd_valid) begin
        rd_ready = (rd_wait >= rd_gap);
        rd_wait++;
      end else begin
        rd_ready = 1'b0;
        rd_wait = 0;
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    chk({tag, "_ctrl"}, {busy, done, ld_ready, rd_valid, acc_start_port, timeout}, 0);
    chk({tag, "_req"}, {S_oe_ram, S_we_ram}, 0);
    chk({tag, "_addr"}, S_addr_ram, 0);
    chk({tag, "_wdata"}, S_Wdata_ram[63:0] | S_Wdata_ram[127:64], 0);
    chk({tag, "_size"}, S_data_ram_size, 0);
    chk({tag, "_rd_data"}, rd_data, 0);
    chk({tag, "_cycles"}, cycles, 0);
  endtask

  // reference: words land in order at BASE+4i, readback is the sorted block
  function automatic logic [NW-1:0][31:0] model_sorted(input logic [NW-1:0][31:0] w);
    logic [31:0] q [$];
    logic [NW-1:0][31:0] r;
    for (int i = 0; i < NW; i++) q.push_back(w[i]);
    q.sort();
    for (int i = 0; i < NW; i++) r[i] = q[i];
    return r;
  endfunction

  function automatic logic [NW-1:0][31:0] mk4(input logic [31:0] a, b, c, d);
    logic [NW-1:0][31:0] r;
    r[0] = a; r[1] = b; r[2] = c; r[3] = d;
    return r;
  endfunction

  task automatic run_seq(input string tag, input logic [NW-1:0][31:0] w,
                         input int lat, input int dly, input int gap,
                         input bit spur, input bit hang, input logic [31:0] exp_cyc,
                         input logic [NW-1:0][31:0] exp_rd);
    int n;
    int b_wr, b_rd, b_we, b_oe, b_st, b_dn, b_pe, b_se;
    b_wr = wr_addr.size(); b_rd = rd_log.size();
    b_we = we_rise; b_oe = oe_rise; b_st = start_cnt; b_dn = done_cnt;
    b_pe = proto_err; b_se = stab_err;
    acc_lat = lat; acc_hang = hang; slv_delay = dly; rd_gap = gap;
    @(negedge clk); go = 1'b1;
    @(negedge clk); go = 1'b0;
    if (spur) begin
      acc_done_force = 1'b1;
      @(negedge clk); acc_done_force = 1'b0;
    end
    for (int i = 0; i < NW; i++) begin
      ld_valid = 1'b1; ld_data = w[i]; n = 0;
      while (!ld_ready && n < 100) begin @(negedge clk); n++; end
      chk($sformatf("%s_ld_hs%0d", tag, i), n < 100, 1);
      @(negedge clk);
    end
    ld_valid = 1'b0; ld_data = '0;
    if (spur) begin
      n = 0;
      while (start_cnt == b_st && n < 100) begin @(negedge clk); n++; end
      go = 1'b1;
      @(negedge clk); go = 1'b0;
    end
    n = 0;
    while (done_cnt == b_dn && n < 600) begin @(negedge clk); n++; end
    chk({tag, "_done_seen"}, n < 600, 1);
    repeat (4) @(negedge clk);
    chk({tag, "_wr_count"}, wr_addr.size() - b_wr, NW);
    chk({tag, "_we_pulses"}, we_rise - b_we, NW);
    for (int i = 0; i < NW; i++)
      if (b_wr + i < wr_addr.size()) begin
        chk($sformatf("%s_wr_addr%0d", tag, i), wr_addr[b_wr + i], 4 * i);
        chk($sformatf("%s_wr_data%0d", tag, i), wr_data[b_wr + i], w[i]);
      end
    chk({tag, "_start_pulses"}, start_cnt - b_st, 1);
    chk({tag, "_done_pulses"}, done_cnt - b_dn, 1);
    chk({tag, "_cycles"}, cycles, exp_cyc);
    chk({tag, "_timeout"}, timeout, hang);
    chk({tag, "_oe_accesses"}, oe_rise - b_oe, hang ? 0 : NW);
    chk({tag, "_rd_count"}, rd_log.size() - b_rd, hang ? 0 : NW);
    if (!hang)
      for (int i = 0; i < NW; i++)
        if (b_rd + i < rd_log.size())
          chk($sformatf("%s_rd%0d", tag, i), rd_log[b_rd + i], exp_rd[i]);
    chk({tag, "_protocol"}, proto_err - b_pe, 0);
    chk({tag, "_stability"}, stab_err - b_se, 0);
    chk({tag, "_busy_after"}, busy, 0);
  endtask

  typedef struct packed {
    logic [NW-1:0][31:0] w;
    logic [NW-1:0][31:0] exp_rd;
    logic [7:0] lat;
    logic [7:0] dly;
    logic [7:0] gap;
    logic spur;
    logic [31:0] exp_cyc;
  } vec_t;

  vec_t tbl [4];

  initial begin
    int n;
    logic [NW-1:0][31:0] w;
    int lat;
    tbl[0] = '{w: mk4(4, 3, 2, 1), exp_rd: mk4(1, 2, 3, 4),
               lat: 10, dly: 0, gap: 0, spur: 0, exp_cyc: 11};
    tbl[1] = '{w: mk4(9, 7, 8, 5), exp_rd: mk4(5, 7, 8, 9),
               lat: 10, dly: 2, gap: 3, spur: 0, exp_cyc: 11};
    tbl[2] = '{w: mk4(32'hFFFF_FFFF, 0, 32'h8000_0000, 1),
               exp_rd: mk4(0, 1, 32'h8000_0000, 32'hFFFF_FFFF),
               lat: 1, dly: 1, gap: 1, spur: 1, exp_cyc: 2};
    tbl[3] = '{w: mk4(5, 5, 5, 5), exp_rd: mk4(5, 5, 5, 5),
               lat: 3, dly: 0, gap: 2, spur: 1, exp_cyc: 4};

    reset = 1'b1; go = 1'b0; ld_valid = 1'b0; ld_data = '0;
    acc_done_force = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_zero("reset");
    reset = 1'b0;
    @(negedge clk);

    for (int k = 0; k < 4; k++)
      run_seq($sformatf("vec%0d", k), tbl[k].w, int'(tbl[k].lat),
              int'(tbl[k].dly), int'(tbl[k].gap), tbl[k].spur, 1'b0,
              tbl[k].exp_cyc, tbl[k].exp_rd);

    // reset while the second preload write is waiting on the slave
    slv_delay = 3;
    @(negedge clk); go = 1'b1;
    @(negedge clk); go = 1'b0;
    for (int i = 0; i < 2; i++) begin
      ld_valid = 1'b1; ld_data = 32'h100 + i; n = 0;
      while (!ld_ready && n < 100) begin @(negedge clk); n++; end
      @(negedge clk);
    end
    ld_valid = 1'b0;
    chk("midrst_we", S_we_ram[0], 1);
    chk("midrst_addr", S_addr_ram[7:0], 4);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_idle_zero("midrst");
    run_seq("after_rst", tbl[1].w, 10, 1, 0, 1'b0, 1'b0, 11, tbl[1].exp_rd);

`ifdef ACCEL_SEQ_WATCHDOG_EN
    run_seq("wdog", mk4(3, 1, 2, 0), 5, 0, 0, 1'b0, 1'b1, 32'(MAXC), mk4(0, 1, 2, 3));
    run_seq("wdog_clr", tbl[0].w, 10, 0, 0, 1'b0, 1'b0, 11, tbl[0].exp_rd);
`endif

    for (int r = 0; r < 10; r++) begin
      for (int i = 0; i < NW; i++)
        w[i] = $urandom_range(0, 1) ? 32'($urandom_range(0, 5)) : $urandom;
      lat = $urandom_range(1, 19);
      run_seq($sformatf("rnd%0d", r), w, lat, $urandom_range(0, 3),
              $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b0,
              32'(lat + 1), model_sorted(w));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete, errors so far %0d", errors);
    $fatal(1, "global timeout");
  end

endmodule
